// File: rtl/risc16_dbus.sv
// Data-side bus unit for risc16f: RAM plus an I/O page (UART TX with FIFO, GPIO, optional timer under RISC16_DBUS_TIMER_EN).
// Reads are combinational (same-cycle load data); writes commit on the rising edge; a full TX FIFO drops bytes and flags overflow.
module risc16_dbus #(
  parameter int RAM_AW     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] dwdata,
  output logic [15:0] drdata,
  input  logic        doe,
  input  logic        dwe,
  output logic        uart_tx,
  output logic [15:0] gpio_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(BAUD_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [15:0] waddr;
  logic        sel_ram, sel_udata, sel_ustat, sel_gpio, sel_timer;
  logic        unused_addr_bit;

  assign waddr           = {daddr[15:1], 1'b0};
  assign unused_addr_bit = daddr[0];
  assign sel_ram         = (daddr[15:RAM_AW+1] == '0);
  assign sel_udata       = (waddr == 16'hFF00);
  assign sel_ustat       = (waddr == 16'hFF02);
  assign sel_gpio        = (waddr == 16'hFF04);
  assign sel_timer       = (waddr == 16'hFF06);

  logic [15:0] ram_q [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (dwe && sel_ram) ram_q[daddr[RAM_AW:1]] <= dwdata;
  end

  logic [15:0] gpio_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 gpio_q <= '0;
    else if (dwe && sel_gpio) gpio_q <= dwdata;
  end

  assign gpio_out = gpio_q;

  // TX FIFO: storage is not reset, flushing is done through the pointers and count.
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q;
  logic             fifo_empty, fifo_full, push_req, push, pop;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             div_end;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign push_req   = dwe && sel_udata;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A pop at the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= dwdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (push_req && !push)                 ovf_q <= 1'b1;
      else if (dwe && sel_ustat && dwdata[3]) ovf_q <= 1'b0;
    end
  end

  assign div_end = (div_q == DIV_W'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_START;
          sh_d    = fifo_q[rd_ptr_q];
          div_d   = '0;
        end
      end
      S_START: begin
        if (div_end) begin
          state_d = S_DATA;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (div_end) begin
          div_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_STOP: begin
        if (div_end) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Decoded straight from state so a reset mid-frame forces the line idle immediately.
  always_comb begin
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = sh_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  logic [15:0] timer_rd;

`ifdef RISC16_DBUS_TIMER_EN
  logic [15:0] timer_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  timer_q <= '0;
    else if (dwe && sel_timer) timer_q <= dwdata;
    else                       timer_q <= timer_q + 1'b1;
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  logic [15:0] stat_rd, rd_sel;

  assign stat_rd = {8'h00, 4'(cnt_q), ovf_q, (state_q != S_IDLE), fifo_full, fifo_empty};

  always_comb begin
    rd_sel = '0;
    if (sel_ram)        rd_sel = ram_q[daddr[RAM_AW:1]];
    else if (sel_ustat) rd_sel = stat_rd;
    else if (sel_gpio)  rd_sel = gpio_q;
    else if (sel_timer) rd_sel = timer_rd;
    drdata = doe ? rd_sel : 16'h0000;
  end

endmodule

// File: tb/tb_risc16_dbus.sv
// Bench for risc16_dbus: vector table for the bus map, scoreboarded UART frames, reset and timer sequences.
module tb_risc16_dbus;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] daddr, dwdata, drdata, gpio_out;
  logic        doe, dwe, uart_tx;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic       exp_tx_q[$];
  logic [7:0] exp_byte_q[$];

  typedef struct {
    logic        we;
    logic        oe;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[19];

  risc16_dbus #(.RAM_AW(12), .FIFO_DEPTH(8), .BAUD_DIV(4)) dut (
    .clk(clk), .rst(rst), .daddr(daddr), .dwdata(dwdata), .drdata(drdata),
    .doe(doe), .dwe(dwe), .uart_tx(uart_tx), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic oe, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    dwe = we; doe = oe; daddr = a; dwdata = d;
    #1;
  endtask

  task automatic rx_frames();
    int         last = -1;
    int         n;
    logic [7:0] rx, ex;
    for (int f = 0; f < 9; f++) begin
      n = 0;
      while (uart_tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      if (uart_tx !== 1'b0) begin
        chk("frame_start_timeout", {15'b0, uart_tx}, 16'h0000);
        break;
      end
      if (f > 0) chk("frame_gap", 16'(cyc - last), 16'd41);
      last = cyc;
      repeat (2) @(negedge clk);
      chk("start_bit", {15'b0, uart_tx}, 16'h0000);
      rx = '0;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        rx[i] = uart_tx;
      end
      repeat (4) @(negedge clk);
      chk("stop_bit", {15'b0, uart_tx}, 16'h0001);
      ex = (exp_byte_q.size() > 0) ? exp_byte_q.pop_front() : 8'hXX;
      chk("frame_data", {8'h00, rx}, {8'h00, ex});
      repeat (2) @(negedge clk);
    end
    n = 0;
    while (uart_tx === 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("no_extra_frame", {15'b0, uart_tx}, 16'h0001);
    chk("byte_queue_empty", 16'(exp_byte_q.size()), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         n;

    vt[0]  = '{1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0000};
    vt[1]  = '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0001};
    vt[2]  = '{1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000};
    vt[3]  = '{1'b1, 1'b0, 16'h0011, 16'hBEEF, 16'h0000};
    vt[4]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF};
    vt[5]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'hBEEF};
    vt[6]  = '{1'b1, 1'b1, 16'hFF04, 16'hA5C3, 16'h0000};
    vt[7]  = '{1'b0, 1'b1, 16'hFF04, 16'h0000, 16'hA5C3};
    vt[8]  = '{1'b0, 1'b0, 16'hFF04, 16'h0000, 16'h0000};
    vt[9]  = '{1'b1, 1'b0, 16'hF000, 16'hFFFF, 16'h0000};
    vt[10] = '{1'b0, 1'b1, 16'hF000, 16'h0000, 16'h0000};
    vt[11] = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0000};
    vt[12] = '{1'b1, 1'b0, 16'h1FFE, 16'h5A5A, 16'h0000};
    vt[13] = '{1'b0, 1'b1, 16'h1FFE, 16'h0000, 16'h5A5A};
    vt[14] = '{1'b0, 1'b1, 16'h2000, 16'h0000, 16'h0000};
    vt[15] = '{1'b1, 1'b1, 16'h0010, 16'h7777, 16'hBEEF};
    vt[16] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h7777};
    vt[17] = '{1'b1, 1'b0, 16'hFF02, 16'h0008, 16'h0000};
    vt[18] = '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0001};

    rst = 1'b0; doe = 1'b0; dwe = 1'b0; daddr = '0; dwdata = '0;
    #1;
    chk("rst_uart_tx", {15'b0, uart_tx}, 16'h0001);
    chk("rst_gpio", gpio_out, 16'h0000);
    chk("rst_drdata", drdata, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].we, vt[i].oe, vt[i].a, vt[i].d);
      chk($sformatf("vec%0d", i), drdata, vt[i].exp);
    end
    chk("gpio_out", gpio_out, 16'hA5C3);

    // Single frame: 0xA5 -> start, 1,0,1,0,0,1,0,1, stop; 4 cycles per bit.
    b = 8'hA5;
    repeat (4) exp_tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (4) exp_tx_q.push_back(b[i]);
    repeat (4) exp_tx_q.push_back(1'b1);
    drive(1'b1, 1'b0, 16'hFF00, 16'h00A5);
    drive(1'b0, 1'b1, 16'hFF02, 16'h0000);
    chk("stat_queued", drdata, 16'h0010);
    chk("tx_idle_before_pop", {15'b0, uart_tx}, 16'h0001);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      chk($sformatf("tx_cycle%0d", c), {15'b0, uart_tx}, {15'b0, exp_tx_q.pop_front()});
      chk($sformatf("busy_cycle%0d", c), {15'b0, drdata[2]}, 16'h0001);
    end
    @(negedge clk); #1;
    chk("tx_after_frame", {15'b0, uart_tx}, 16'h0001);
    chk("stat_after_frame", drdata, 16'h0001);

    // Ten back-to-back writes: first pops at once, next eight fill the FIFO, tenth overflows.
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          drive(1'b1, 1'b0, 16'hFF00, 16'h0030 + 16'(k));
          if (k < 9) exp_byte_q.push_back(8'h30 + 8'(k));
        end
        drive(1'b0, 1'b1, 16'hFF02, 16'h0000);
        chk("stat_full_ovf", drdata, 16'h008E);
        drive(1'b1, 1'b0, 16'hFF02, 16'h0008);
        drive(1'b0, 1'b1, 16'hFF02, 16'h0000);
        chk("stat_ovf_cleared", drdata, 16'h0086);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      rx_frames();
    join
    drive(1'b0, 1'b1, 16'hFF02, 16'h0000);
    chk("stat_drained", drdata, 16'h0001);

    // Reset during DATA bit 3 of a 0x00 frame with two more bytes queued.
    drive(1'b1, 1'b0, 16'hFF04, 16'h1234);
    drive(1'b1, 1'b0, 16'hFF00, 16'h0000);
    drive(1'b1, 1'b0, 16'hFF00, 16'h00FF);
    drive(1'b1, 1'b0, 16'hFF00, 16'h00FF);
    drive(1'b0, 1'b1, 16'hFF02, 16'h0000);
    repeat (15) @(negedge clk);
    #1;
    chk("pre_rst_tx", {15'b0, uart_tx}, 16'h0000);
    chk("pre_rst_stat", drdata, 16'h0024);
    chk("pre_rst_gpio", gpio_out, 16'h1234);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_tx", {15'b0, uart_tx}, 16'h0001);
    chk("rst_mid_stat", drdata, 16'h0001);
    chk("rst_mid_gpio", gpio_out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (50) begin @(negedge clk); if (uart_tx !== 1'b1) n++; end
    chk("no_tx_after_flush", 16'(n), 16'd0);

    drive(1'b1, 1'b0, 16'hFF06, 16'hFFFE);
`ifdef RISC16_DBUS_TIMER_EN
    drive(1'b0, 1'b1, 16'hFF06, 16'h0000);
    chk("timer_load", drdata, 16'hFFFE);
    drive(1'b0, 1'b1, 16'hFF06, 16'h0000);
    chk("timer_inc", drdata, 16'hFFFF);
    drive(1'b0, 1'b1, 16'hFF06, 16'h0000);
    chk("timer_wrap", drdata, 16'h0000);
`else
    drive(1'b0, 1'b1, 16'hFF06, 16'h0000);
    chk("timer_absent0", drdata, 16'h0000);
    drive(1'b0, 1'b1, 16'hFF06, 16'h0000);
    chk("timer_absent1", drdata, 16'h0000);
`endif
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
